// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// State encodings and the default reset PC live here.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_BUF  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // J-type target: upper nibble of the delay-free pc+4 plus the 26-bit index.
    function automatic logic [31:0] jump_target(input logic [31:0] pcplus4,
                                                input logic [31:0] instr);
        return {pcplus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
// Handshake: imem_req is held high with imem_addr stable until a one-cycle
// imem_ack, which also marks imem_rdata valid in that same cycle.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_ack, input  imem_rdata);
    modport slave  (input  imem_req, input  imem_addr,
                    output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_stage_flopenrc.sv
// Register with enable, asynchronous reset and synchronous clear.
// Clear takes priority over enable.
module if_stage_flopenrc #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= d;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, request FSM (REQ/BUF/DROP) and the IF/ID register.
// Optional macro IF_PC_ALIGN_CHECK_EN adds adel_f and blocks misaligned fetches.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  imem,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        branch_d,
    input  logic [31:0] pc_branch_d,
    input  logic        jump_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d,
`ifdef IF_PC_ALIGN_CHECK_EN
    output logic        adel_f,
`endif
    output state_t      state_dbg
);

    state_t      state_q, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] buf_q, buf_n;
    logic [31:0] stale_q, stale_n;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_addr;
    logic        redirect;
    logic [31:0] target;
    logic        misaligned;
    logic        load_word;
    logic [31:0] word;
    logic        req_c;
    logic [31:0] addr_c;

    assign pc_plus4   = pc_q + 32'd4;
    assign fetch_addr = {pc_q[31:2], 2'b00};
    assign redirect   = jump_d | branch_d;
    assign target     = jump_d ? jump_target(pcplus4_d, instr_d) : pc_branch_d;

`ifdef IF_PC_ALIGN_CHECK_EN
    assign misaligned = |pc_q[1:0];
    assign adel_f     = (state_q == ST_REQ) && misaligned;
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
            stale_q <= '0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            buf_q   <= buf_n;
            stale_q <= stale_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        pc_n      = pc_q;
        buf_n     = buf_q;
        stale_n   = stale_q;
        load_word = 1'b0;
        word      = imem.imem_rdata;
        req_c     = 1'b0;
        addr_c    = fetch_addr;
        unique case (state_q)
            ST_REQ: begin
                req_c = !misaligned;
                if (redirect) begin
                    pc_n = target;
                    // An unanswered request must still be drained before refetching.
                    if (!misaligned && !imem.imem_ack) begin
                        state_n = ST_DROP;
                        stale_n = fetch_addr;
                    end
                end else if (!misaligned && imem.imem_ack) begin
                    if (stall_d) begin
                        buf_n   = imem.imem_rdata;
                        state_n = ST_BUF;
                    end else begin
                        load_word = 1'b1;
                        pc_n      = pc_plus4;
                    end
                end
            end
            ST_BUF: begin
                if (redirect) begin
                    pc_n    = target;
                    state_n = ST_REQ;
                end else if (!stall_d) begin
                    load_word = 1'b1;
                    word      = buf_q;
                    pc_n      = pc_plus4;
                    state_n   = ST_REQ;
                end
            end
            ST_DROP: begin
                req_c  = 1'b1;
                addr_c = stale_q;
                if (redirect)       pc_n    = target;
                if (imem.imem_ack)  state_n = ST_REQ;
            end
            default: state_n = ST_REQ;
        endcase
    end

    assign imem.imem_req  = req_c;
    assign imem.imem_addr = addr_c;
    assign state_dbg      = state_q;

    // IF/ID register: flush clears, stall holds, otherwise load a word or a bubble.
    if_stage_flopenrc #(.W(32)) u_instr (
        .clk(clk), .rst(rst), .en(load_word), .clr(flush_d), .d(word), .q(instr_d)
    );
    if_stage_flopenrc #(.W(32)) u_pc (
        .clk(clk), .rst(rst), .en(load_word), .clr(flush_d), .d(pc_q), .q(pc_d)
    );
    if_stage_flopenrc #(.W(32)) u_pcplus4 (
        .clk(clk), .rst(rst), .en(load_word), .clr(flush_d), .d(pc_plus4), .q(pcplus4_d)
    );
    if_stage_flopenrc #(.W(1)) u_valid (
        .clk(clk), .rst(rst), .en(!stall_d), .clr(flush_d), .d(load_word), .q(valid_d)
    );

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage with an instruction-memory responder and a
// transaction-level fetch model feeding an expected-delivery queue.
module tb_if_stage;
  import if_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_stage_if imem_bus();

  logic        stall_d, flush_d, branch_d, jump_d;
  logic [31:0] pc_branch_d;
  logic [31:0] instr_d, pc_d, pcplus4_d;
  logic        valid_d;
  state_t      state_dbg;
`ifdef IF_PC_ALIGN_CHECK_EN
  logic        adel_f;
`endif

  if_stage dut (
    .clk(clk), .rst(rst), .imem(imem_bus),
    .stall_d(stall_d), .flush_d(flush_d), .branch_d(branch_d),
    .pc_branch_d(pc_branch_d), .jump_d(jump_d),
    .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d),
`ifdef IF_PC_ALIGN_CHECK_EN
    .adel_f(adel_f),
`endif
    .state_dbg(state_dbg)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [95:0] exp_q[$];

  // reference model: next fetch pc, a word waiting on a stalled decoder,
  // a stale request whose answer must be discarded, and the expected IF/ID view
  logic [31:0] m_pc, m_held_word, m_stale;
  bit          m_held, m_discard;
  logic [31:0] m_instr, m_pc_d, m_pcp4;
  bit          m_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h0123_4567;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_held = 0; m_held_word = 0; m_discard = 0; m_stale = 0;
    m_instr = 0; m_pc_d = 0; m_pcp4 = 0; m_valid = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit ack, input bit stall, input bit flush,
                            input bit br, input bit jp, input logic [31:0] pcb);
    logic [31:0] target, faddr, w, wpc;
    bit redirect, deliver;
    redirect = br | jp;
    target   = jp ? {m_pcp4[31:28], m_instr[25:0], 2'b00} : pcb;
    faddr    = {m_pc[31:2], 2'b00};
    deliver  = 0;
    w = 0; wpc = 0;
    if (m_discard) begin
      if (redirect) m_pc = target;
      if (ack) m_discard = 0;
    end else if (m_held) begin
      if (redirect) begin
        m_held = 0; m_pc = target;
      end else if (!stall) begin
        deliver = 1; w = m_held_word; wpc = m_pc; m_held = 0; m_pc = m_pc + 32'd4;
      end
    end else begin
      if (redirect) begin
        if (!ack) begin m_discard = 1; m_stale = faddr; end
        m_pc = target;
      end else if (ack) begin
        if (stall) begin
          m_held = 1; m_held_word = mem_word(faddr);
        end else begin
          deliver = 1; w = mem_word(faddr); wpc = m_pc; m_pc = m_pc + 32'd4;
        end
      end
    end
    if (flush) begin
      m_instr = 0; m_pc_d = 0; m_pcp4 = 0; m_valid = 0;
    end else if (!stall) begin
      if (deliver) begin
        m_instr = w; m_pc_d = wpc; m_pcp4 = wpc + 32'd4; m_valid = 1;
        exp_q.push_back({w, wpc, wpc + 32'd4});
      end else begin
        m_valid = 0;
      end
    end
  endtask

  // one clock of stimulus, entered and left just after a falling edge
  task automatic drive_cycle(input bit quiet, input bit directed);
    bit ack, stall, flush, br, jp, exp_req;
    logic [31:0] pcb;
    logic [1:0]  exp_state;
    exp_req   = !m_held;
    exp_state = m_discard ? 2'd2 : (m_held ? 2'd1 : 2'd0);
    check32("imem_req", {31'b0, imem_bus.imem_req}, {31'b0, exp_req});
    if (exp_req)
      check32("imem_addr", imem_bus.imem_addr, m_discard ? m_stale : {m_pc[31:2], 2'b00});
    check32("state", {30'b0, state_dbg}, {30'b0, exp_state});
    ack   = exp_req && (directed || $urandom_range(0, 9) < 6);
    stall = !quiet && !directed && ($urandom_range(0, 99) < 25);
    flush = !quiet && !directed && ($urandom_range(0, 99) < 5);
    br    = !quiet && !directed && ($urandom_range(0, 99) < 8);
    jp    = !quiet && !directed && ($urandom_range(0, 99) < 6);
    if ($urandom_range(0, 3) == 0) pcb = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
    else                           pcb = $urandom & 32'hFFFF_FFFC;
    stall_d = stall; flush_d = flush; branch_d = br; jump_d = jp; pc_branch_d = pcb;
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = ack ? mem_word(imem_bus.imem_addr) : $urandom;
    model_step(ack, stall, flush, br, jp, pcb);
    @(negedge clk);
  endtask

  // monitor: after each rising edge, pop and compare any delivered word
  initial begin
    bit s, f, r;
    logic [95:0] e;
    forever begin
      @(posedge clk);
      s = stall_d; f = flush_d; r = rst;
      #1;
      if (!r && !rst) begin
        if (f) begin
          check32("flush_valid", {31'b0, valid_d}, 32'd0);
          check32("flush_instr", instr_d, 32'd0);
        end else if (!s) begin
          if (valid_d) begin
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL delivery: got unexpected word %h at pc %h, expected none", instr_d, pc_d);
            end else begin
              e = exp_q.pop_front();
              check32("instr_d", instr_d, e[95:64]);
              check32("pc_d", pc_d, e[63:32]);
              check32("pcplus4_d", pcplus4_d, e[31:0]);
            end
          end else begin
            vectors++;
            if (exp_q.size() != 0) begin
              miscompares++;
              e = exp_q.pop_front();
              $display("FAIL delivery: got bubble, expected word %h at pc %h", e[95:64], e[63:32]);
            end
          end
        end else begin
          check32("held_instr", instr_d, m_instr);
          check32("held_valid", {31'b0, valid_d}, {31'b0, m_valid});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    stall_d = 0; flush_d = 0; branch_d = 0; jump_d = 0; pc_branch_d = 0;
    imem_bus.imem_ack = 0; imem_bus.imem_rdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check32("reset_valid", {31'b0, valid_d}, 32'd0);
    check32("reset_instr", instr_d, 32'd0);
    check32("reset_pc_d", pc_d, 32'd0);
    check32("reset_pcplus4", pcplus4_d, 32'd0);
    check32("reset_state", {30'b0, state_dbg}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == 2000) begin
        // reset in the middle of traffic, possibly with a request outstanding
        rst = 1'b1;
        imem_bus.imem_ack = 0;
        stall_d = 0; flush_d = 0; branch_d = 0; jump_d = 0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end
      drive_cycle(1'b0, (cyc < 6) || (cyc >= 2000 && cyc < 2004));
    end
    for (int k = 0; k < 6; k++) drive_cycle(1'b1, 1'b0);
    @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d undelivered words, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
